// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-save packet accumulator.
package csa_accumulator_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/csa_accumulator_csa.sv
// Carry-save (3:2) stage: s + c == x + y + z, no carry propagation.
module csa #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] y,
    input  logic [BITS-1:0] z,
    output logic [BITS-1:0] s,
    output logic [BITS-1:0] c
);

    logic [BITS-1:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    assign c   = maj << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: running total kept in carry-save form,
// resolved with a single carry-propagate add at the end of each packet.
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned AW = DATA_W + 1;
    // Bits above DATA_W never affect the result mod 2^DATA_W, so they are dropped on feedback.
    localparam logic [AW-1:0] LOW_MASK = {1'b0, {DATA_W{1'b1}}};

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic [AW-1:0]     csa_s, csa_c;
    logic [CNT_W-1:0]  count_q, count_d, count_inc;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] out_sum_q, out_sum_d, resolved;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              accept, at_max;

    csa #(.BITS(AW)) u_csa (
        .x (acc_s_q),
        .y (acc_c_q),
        .z ({1'b0, in_data}),
        .s (csa_s),
        .c (csa_c)
    );

    assign accept    = in_valid && (state_q == ST_ACCUM);
    assign count_inc = count_q + 1'b1;
    assign at_max    = (count_inc == '1);
    assign resolved  = DATA_W'(acc_s_q + acc_c_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:   if (accept && (in_last || at_max)) state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_DONE;
            ST_DONE:    if (out_ready) state_d = ST_ACCUM;
            default:    state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_ACCUM);
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    acc_s_d = csa_s & LOW_MASK;
                    acc_c_d = csa_c & LOW_MASK;
                    count_d = count_inc;
                    ovf_d   = at_max && !in_last;
                end
            end
            ST_RESOLVE: begin
                out_sum_d   = resolved;
                out_count_d = count_q;
                out_ovf_d   = ovf_q;
                out_valid_d = 1'b1;
                acc_s_d     = '0;
                acc_c_d     = '0;
                count_d     = '0;
                ovf_d       = 1'b0;
            end
            ST_DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomized checks of csa_accumulator against a packet-sum scoreboard.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf, out_valid, out_ready;

    logic [15:0] s_in_data;
    logic        s_in_valid, s_in_last, s_in_ready;
    logic [15:0] s_out_sum;
    logic [2:0]  s_out_count;
    logic        s_out_ovf, s_out_valid, s_out_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] sum;
        int          cnt;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_sum;
    int          m_cnt;
    int          n_results;

    always #5 clk = ~clk;

    csa_accumulator #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    csa_accumulator #(.DATA_W(16), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_last(s_in_last), .in_ready(s_in_ready), .out_sum(s_out_sum),
        .out_count(s_out_count), .out_ovf(s_out_ovf), .out_valid(s_out_valid),
        .out_ready(s_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_op(input logic [15:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 50) begin cyc(); n++; end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic s_send(input logic [15:0] d, input logic l);
        int n = 0;
        s_in_valid = 1'b1; s_in_data = d; s_in_last = l;
        while (!s_in_ready && n < 50) begin cyc(); n++; end
        chk("s_send_ready", {31'd0, s_in_ready}, 32'd1);
        cyc();
        s_in_valid = 1'b0; s_in_last = 1'b0;
    endtask

    // One clock of the randomized phase: score the handshakes seen before the edge.
    task automatic rstep(output bit acc);
        exp_t e;
        bit   xf;
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        if (xf) begin
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_sum", {16'd0, out_sum}, {16'd0, e.sum});
                chk("rand_count", {24'd0, out_count}, e.cnt);
                chk("rand_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                n_results++;
            end
        end
        if (acc) begin
            m_sum = m_sum + in_data;
            m_cnt++;
            if (in_last || m_cnt == 255) begin
                exp_q.push_back('{sum: m_sum, cnt: m_cnt, ovf: !in_last});
                m_sum = '0;
                m_cnt = 0;
            end
        end
        cyc();
    endtask

    initial begin
        int  n;
        int  pk, pos, len, budget;
        bit  acc;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        s_in_data = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;

        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_sum", {16'd0, out_sum}, 32'd0);
        chk("reset_out_count", {24'd0, out_count}, 32'd0);
        chk("reset_out_ovf", {31'd0, out_ovf}, 32'd0);

        // 3 + 5 + 7, result visible two edges after the last accept
        send_op(16'd3, 1'b0);
        send_op(16'd5, 1'b0);
        send_op(16'd7, 1'b1);
        chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
        chk("resolve_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("p1_valid", {31'd0, out_valid}, 32'd1);
        chk("p1_sum", {16'd0, out_sum}, 32'd15);
        chk("p1_count", {24'd0, out_count}, 32'd3);
        chk("p1_ovf", {31'd0, out_ovf}, 32'd0);
        cyc();
        chk("p1_after_xfer_valid", {31'd0, out_valid}, 32'd0);
        chk("p1_after_xfer_ready", {31'd0, in_ready}, 32'd1);

        // wrap: 0xFFFF + 0x0002
        send_op(16'hFFFF, 1'b0);
        send_op(16'h0002, 1'b1);
        cyc();
        chk("wrap_sum", {16'd0, out_sum}, 32'h0001);
        chk("wrap_count", {24'd0, out_count}, 32'd2);
        cyc();

        // backpressure: result held while out_ready is low
        out_ready = 1'b0;
        send_op(16'd4, 1'b1);
        cyc();
        in_valid = 1'b1; in_data = 16'd10; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", {16'd0, out_sum}, 32'd4);
            chk("bp_count", {24'd0, out_count}, 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_released_valid", {31'd0, out_valid}, 32'd0);
        send_op(16'd10, 1'b1);
        cyc();
        chk("bp_next_sum", {16'd0, out_sum}, 32'd10);
        chk("bp_next_count", {24'd0, out_count}, 32'd1);
        cyc();

        // count limit on the CNT_W=3 instance: force-close at 7 operands
        for (int i = 0; i < 7; i++) s_send(16'd1, 1'b0);
        chk("ovf_resolve_valid", {31'd0, s_out_valid}, 32'd0);
        chk("ovf_resolve_ready", {31'd0, s_in_ready}, 32'd0);
        s_in_valid = 1'b1; s_in_data = 16'd1; s_in_last = 1'b0;
        cyc();
        chk("ovf_valid", {31'd0, s_out_valid}, 32'd1);
        chk("ovf_sum", {16'd0, s_out_sum}, 32'd7);
        chk("ovf_count", {29'd0, s_out_count}, 32'd7);
        chk("ovf_flag", {31'd0, s_out_ovf}, 32'd1);
        cyc();
        chk("ovf_realign_ready", {31'd0, s_in_ready}, 32'd1);
        cyc();
        s_in_valid = 1'b0;
        s_send(16'd5, 1'b1);
        cyc();
        chk("ovf_next_valid", {31'd0, s_out_valid}, 32'd1);
        chk("ovf_next_sum", {16'd0, s_out_sum}, 32'd6);
        chk("ovf_next_count", {29'd0, s_out_count}, 32'd2);
        chk("ovf_next_flag", {31'd0, s_out_ovf}, 32'd0);
        cyc();

        // reset mid-packet discards partial state
        send_op(16'd1, 1'b0);
        send_op(16'd2, 1'b0);
        send_op(16'd3, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_ready", {31'd0, in_ready}, 32'd1);
            cyc();
        end
        send_op(16'd9, 1'b1);
        cyc();
        chk("midrst_valid", {31'd0, out_valid}, 32'd1);
        chk("midrst_sum", {16'd0, out_sum}, 32'd9);
        chk("midrst_count", {24'd0, out_count}, 32'd1);
        cyc();

        // randomized packets with gaps on both sides
        m_sum = '0; m_cnt = 0; n_results = 0;
        pk = 0; pos = 0; len = $urandom_range(1, 20); budget = 6000;
        while (pk < 40 && budget > 0) begin
            if (!in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = 16'($urandom);
                    in_last  = (pos == len - 1);
                end else begin
                    in_data = 16'($urandom);
                    in_last = 1'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            rstep(acc);
            if (acc) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                pos++;
                if (pos == len) begin
                    pk++;
                    pos = 0;
                    len = $urandom_range(1, 20);
                end
            end
            budget--;
        end
        chk("rand_budget", {31'd0, (budget > 0)}, 32'd1);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            rstep(acc);
            n++;
        end
        chk("rand_queue_drained", exp_q.size(), 32'd0);
        chk("rand_result_count", n_results, 32'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
